mem_bridge: RTL
===============

// Module: mem_bridge
// PURPOSE
//  Bus slave directly downstream of the riscv core: terminates its req/we/adr/dat/byteNr/done memory port.
//  Drives one 32-bit synchronous single-port RAM (1-cycle read latency, per-byte write enables).
//  Converts byte-addressed 1/2/4-byte accesses into word accesses, including misaligned ones.
//  Misaligned accesses are split into two word accesses; range and size faults are reported.
// PARAMETERS
//  AW           10      RAM word-address width (depth = 2**AW words)
//  BASE         32'h0   byte base address of the RAM window (low AW+2 bits ignored)
//  WAIT_STATES  0       extra cycles added to each RAM access (0..15)
// PORTS
//  clk_i        in   1   clock, all logic on rising edge
//  rst_ni       in   1   asynchronous, active-low reset
//  req_i        in   1   access request from the core; held until done_o
//  we_i         in   1   1 = write, 0 = read; sampled with req_i
//  adr_i        in   32  byte address
//  dat_i        in   32  write data, right-aligned (byte 0 in [7:0])
//  byteNr_i     in   3   access size in bytes; legal values 1, 2, 4
//  dat_o        out  32  read data, right-aligned, unused upper bytes zero; valid while done_o=1
//  done_o       out  1   one-cycle pulse ending the transaction
//  err_o        out  1   qualifies done_o: access rejected
//  mem_en_o     out  1   RAM access strobe, one cycle per word access
//  mem_we_o     out  1   RAM write
//  mem_be_o     out  4   RAM byte enables
//  mem_adr_o    out  AW  RAM word address
//  mem_wdat_o   out  32  RAM write data, lane-aligned
//  mem_rdat_i   in   32  RAM read data, valid the cycle after mem_en_o
// BEHAVIOUR
//  Reset (rst_ni=0, asynchronous): state=IDLE.
//   Outputs during reset: done_o=0, err_o=0, dat_o=0, mem_en_o=0, mem_we_o=0, mem_be_o=0, mem_adr_o=0, mem_wdat_o=0.
//  Reset mid-operation aborts immediately.
//   The first half of a split store may already be written; this is accepted.
//  FSM states: IDLE, P0, W0, P1, W1, RESP. All outputs are registered or decoded from registered state.
//  IDLE: when req_i=1, capture we/adr/dat/byteNr, then:
//   - error -> RESP with err=1;
//   - otherwise -> P0.
//  Error conditions (no RAM access is made):
//   - byteNr not in {1,2,4};
//   - adr_i[31:AW+2] != BASE[31:AW+2];
//   - access is split and word A+1 wraps past 2**AW-1.
//  Lane math: off=adr[1:0], A=adr[AW+1:2].
//   - 8-bit mask M = ((1<<byteNr)-1)<<off.
//   - Access is split iff off+byteNr>4.
//   - Write data: W64 = {32'b0,dat}<<(8*off); half0 = W64[31:0], half1 = W64[63:32].
//  P0: mem_en_o=1, mem_adr_o=A, mem_be_o=M[3:0], mem_we_o=we, mem_wdat_o=half0 -> W0.
//  W0: lasts WAIT_STATES+1 cycles; on the last cycle capture mem_rdat_i into R0.
//   - Then -> P1 if split, else -> RESP.
//  P1: same as P0 with adr=A+1, be=M[7:4], wdat=half1 -> W1.
//  W1: lasts WAIT_STATES+1 cycles; capture R1 on the last cycle -> RESP.
//  RESP: done_o=1 for exactly one cycle -> IDLE.
//   - Read: dat_o = ({R1,R0}>>(8*off)) with bytes >= byteNr zeroed. R1 is treated as 0 if the access was not split.
//   - Write: dat_o=0.
//   - Error: dat_o=0, err_o=1.
//  Latency from the cycle req_i is first seen high to done_o:
//   - aligned/non-split: 3+WAIT_STATES cycles;
//   - split: 5+2*WAIT_STATES cycles;
//   - error: 1 cycle.
//  req_i dropping mid-transaction is ignored; the transaction completes and done_o still pulses.
//  req_i high in the cycle after RESP is a new request; back-to-back requests need no idle gap.
//  Inputs are captured only in IDLE; changes to adr/dat during a transaction have no effect.
//  mem_en_o is 0 in every state except P0 and P1.
// TESTING
//  Setup: BASE=0, AW=10, WAIT_STATES=0, RAM preloaded with word0=32'h44332211 and word1=32'h88776655.
//  1. Read adr=0, byteNr=4 -> one mem_en pulse; done on cycle 3; dat_o=32'h44332211, err_o=0.
//  2. Read adr=3, byteNr=2 (split) -> two mem_en pulses (adr 0 then 1, be 4'b1000 then 4'b0001);
//     done on cycle 5; dat_o=32'h00005544.
//  3. Write adr=6, byteNr=1, dat=32'hFFFFFFAB -> single access: be=4'b0100, wdat=32'h00AB0000;
//     a following read of adr=4, byteNr=4 returns 32'h88AB6655.
//  4. Error cases, each giving done+err on cycle 1 with no mem_en_o:
//     - byteNr=3;
//     - adr=32'h00001000;
//     - adr=32'h00000FFE with byteNr=4.
//  5. WAIT_STATES=2, read adr=0, byteNr=4 -> done on cycle 5.
//     Then an immediate back-to-back fetch-then-load pair -> both complete with correct data.
//  6. rst_ni pulsed low during W0 of a split store -> all outputs 0 immediately; FSM in IDLE;
//     the next request completes normally.

Source files
------------

// File: rtl/mem_bridge.sv
// mem_bridge: terminates the core's req/we/adr/dat/byteNr/done port on a
// 32-bit synchronous single-port RAM. Byte-addressed 1/2/4-byte accesses are
// turned into one or two word accesses; misaligned accesses that straddle a
// word boundary are split in two. Range and size faults end with err_o.
//
// Core-side handshake: req_i is sampled only in IDLE. The transaction ends
// with a single-cycle done_o pulse, qualified by err_o and carrying dat_o.
// req_i may drop after it has been sampled. A request held high in the cycle
// after done_o starts the next transaction.
module mem_bridge #(
  parameter int          AW          = 10,
  parameter logic [31:0] BASE        = 32'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [31:0]   adr_i,
  input  logic [31:0]   dat_i,
  input  logic [2:0]    byteNr_i,
  output logic [31:0]   dat_o,
  output logic          done_o,
  output logic          err_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [31:0]   mem_wdat_o,
  input  logic [31:0]   mem_rdat_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    W0   = 3'd2,
    P1   = 3'd3,
    W1   = 3'd4,
    RESP = 3'd5
  } state_t;

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  // Byte-lane mask of a right-aligned access of n bytes (0 for illegal sizes).
  function automatic logic [3:0] size_mask(input logic [2:0] n);
    logic [3:0] m;
    case (n)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd4:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Bit mask that keeps the low n bytes of a word.
  function automatic logic [31:0] keep_mask(input logic [2:0] n);
    logic [3:0] m;
    m = size_mask(n);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   a_q, a_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [2:0]      nr_q, nr_d;
  logic            split_q, split_d;
  logic            err_q, err_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [31:0]     r0_q, r0_d;
  logic [31:0]     r1_q, r1_d;

  // Request decode, evaluated on the raw inputs while IDLE.
  logic [3:0] req_end;
  logic       split_in, size_ok, range_ok, wrap, err_in;

  assign req_end  = {2'b00, adr_i[1:0]} + {1'b0, byteNr_i};
  assign split_in = (req_end > 4'd4);
  assign size_ok  = (byteNr_i == 3'd1) || (byteNr_i == 3'd2) || (byteNr_i == 3'd4);
  assign range_ok = (adr_i[31:AW+2] == BASE[31:AW+2]);
  assign wrap     = split_in && (adr_i[AW+1:2] == {AW{1'b1}});
  assign err_in   = !size_ok || !range_ok || wrap;

  // Lane math on the captured request.
  logic [7:0]    mask8;
  logic [63:0]   w64;
  logic [31:0]   rd_lo;
  logic          last_wait;
  logic [AW-1:0] a_next;

  assign mask8     = {4'b0000, size_mask(nr_q)} << off_q;
  assign w64       = {32'b0, wdat_q} << {off_q, 3'b000};
  assign rd_lo     = 32'({r1_q, r0_q} >> {off_q, 3'b000});
  assign last_wait = (wcnt_q == WS);
  assign a_next    = a_q + {{(AW-1){1'b0}}, 1'b1};

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      off_q   <= 2'b00;
      a_q     <= '0;
      wdat_q  <= 32'b0;
      nr_q    <= 3'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= 4'b0;
      r0_q    <= 32'b0;
      r1_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      off_q   <= off_d;
      a_q     <= a_d;
      wdat_q  <= wdat_d;
      nr_q    <= nr_d;
      split_q <= split_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
    end
  end

  // Next-state logic: capture in IDLE, walk one or two word accesses, respond.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    off_d   = off_q;
    a_d     = a_q;
    wdat_d  = wdat_q;
    nr_d    = nr_q;
    split_d = split_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          off_d   = adr_i[1:0];
          a_d     = adr_i[AW+1:2];
          // Bytes above the access size are dropped so disabled lanes carry zero.
          wdat_d  = dat_i & keep_mask(byteNr_i);
          nr_d    = byteNr_i;
          split_d = split_in;
          err_d   = err_in;
          r0_d    = 32'b0;
          r1_d    = 32'b0;
          state_d = err_in ? RESP : P0;
        end
      end
      P0: begin
        wcnt_d  = 4'b0;
        state_d = W0;
      end
      W0: begin
        if (last_wait) begin
          r0_d    = mem_rdat_i;
          state_d = split_q ? P1 : RESP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      P1: begin
        wcnt_d  = 4'b0;
        state_d = W1;
      end
      W1: begin
        if (last_wait) begin
          r1_d    = mem_rdat_i;
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; everything is zero outside its state.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'b0;
    mem_adr_o  = '0;
    mem_wdat_o = 32'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    dat_o      = 32'b0;
    case (state_q)
      P0: begin
        mem_en_o   = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = mask8[3:0];
        mem_adr_o  = a_q;
        mem_wdat_o = w64[31:0];
      end
      P1: begin
        mem_en_o   = 1'b1;
        mem_we_o   = we_q;
        mem_be_o   = mask8[7:4];
        mem_adr_o  = a_next;
        mem_wdat_o = w64[63:32];
      end
      RESP: begin
        done_o = 1'b1;
        err_o  = err_q;
        if (!we_q && !err_q) dat_o = rd_lo & keep_mask(nr_q);
      end
      default: ;
    endcase
  end

endmodule
